// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_MEM = 2'd1,
        FAULT    = 2'd2
    } state_e;

    localparam int DEF_MEM_TIMEOUT = 16;
    localparam int DEF_REG_AW      = 5;
    localparam int ZERO_REG        = 0;

endpackage

// File: rtl/hazard_sat_cnt.sv
// 32-bit saturating event counter; sticks at all-ones instead of wrapping.
module hazard_sat_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [31:0] count
);

    logic [31:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != 32'hFFFF_FFFF))
            count_d = count_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= 32'd0;
        else     count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, branch squash, memory wait + timeout.
// Optional HAZ_PERF_EN adds saturating stall/flush event counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int REG_AW      = DEF_REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              branch_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              memwb_flush,
    output logic              fault,
    output logic              busy
`ifdef HAZ_PERF_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_events
`endif
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [REG_AW-1:0] ZR = REG_AW'(ZERO_REG);

    state_e          state_q, state_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            mem_stall, load_use;

    assign mem_stall = mem_req & ~mem_ready;
    assign load_use  = ex_mem_read & (ex_rd != ZR) &
                       ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;
        fault       = 1'b0;
        busy        = 1'b0;
        if (rst) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
            {ifid_flush, idex_flush, memwb_flush}         = 3'b111;
        end else begin
            case (state_q)
                RUN: begin
                    if (mem_stall) begin
                        {pc_en, ifid_en, idex_en, exmem_en} = 4'b0;
                        memwb_flush = 1'b1;
                        state_d     = WAIT_MEM;
                        wait_cnt_d  = CW'(1);
                    end else if (branch_taken) begin
                        // squash wins over load-use: the dependent instruction is discarded anyway
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (load_use) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
                WAIT_MEM: begin
                    busy = 1'b1;
                    if (mem_ready) begin
                        state_d    = RUN;
                        wait_cnt_d = '0;
                    end else begin
                        {pc_en, ifid_en, idex_en, exmem_en} = 4'b0;
                        memwb_flush = 1'b1;
                        wait_cnt_d  = wait_cnt_q + CW'(1);
                        // the wait cycle that completes the budget sends us to FAULT next
                        if (wait_cnt_d == CW'(MEM_TIMEOUT))
                            state_d = FAULT;
                    end
                end
                FAULT: begin
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
                    memwb_flush = 1'b1;
                    fault       = 1'b1;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

`ifdef HAZ_PERF_EN
    logic stall_inc, flush_inc;

    assign stall_inc = ~rst & (state_q != FAULT) & ~pc_en;
    assign flush_inc = ~rst & (state_q == RUN) & ~mem_stall & branch_taken;

    hazard_sat_cnt u_stall_cnt (.clk(clk), .rst(rst), .inc(stall_inc), .count(stall_cycles));
    hazard_sat_cnt u_flush_cnt (.clk(clk), .rst(rst), .inc(flush_inc), .count(flush_events));
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: directed literal checks plus randomized run against a run-length model.
module tb_pipeline_hazard_ctrl;

    localparam int TO = 4;
    localparam int AW = 5;

    localparam logic [9:0] DEF  = 10'b11111_000_00;
    localparam logic [9:0] RSTV = 10'b00000_111_00;
    localparam logic [9:0] FRZ  = 10'b00001_001_00;
    localparam logic [9:0] FRZB = 10'b00001_001_01;
    localparam logic [9:0] LU   = 10'b00111_010_00;
    localparam logic [9:0] BR   = 10'b11111_110_00;
    localparam logic [9:0] REL  = 10'b11111_000_01;
    localparam logic [9:0] FLT  = 10'b00000_001_10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [AW-1:0] id_rs = '0, id_rt = '0, ex_rd = '0;
    logic id_uses_rt = 1'b0, ex_mem_read = 1'b0, branch_taken = 1'b0;
    logic mem_req = 1'b0, mem_ready = 1'b0;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, memwb_flush, fault, busy;
`ifdef HAZ_PERF_EN
    logic [31:0] stall_cycles, flush_events;
`endif
    logic [9:0] outs;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .REG_AW(AW)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .memwb_flush(memwb_flush), .fault(fault), .busy(busy)
`ifdef HAZ_PERF_EN
        , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
    );

    assign outs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                   ifid_flush, idex_flush, memwb_flush, fault, busy};

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: remembers only whether the previous cycle was a memory wait, how long the
    // current run of wait cycles is, and whether the timeout has already fired.
    bit      m_wait  = 1'b0;
    bit      m_fault = 1'b0;
    int      m_run   = 0;
    longint  m_stalls = 0;
    longint  m_flushes = 0;

    function automatic bit waiting_now();
        return m_wait ? !mem_ready : (mem_req && !mem_ready);
    endfunction

    function automatic logic [9:0] model_out();
        logic lu;
        lu = ex_mem_read && (ex_rd != 0) &&
             ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
        if (rst)           return RSTV;
        if (m_fault)       return FLT;
        if (waiting_now()) return m_wait ? FRZB : FRZ;
        if (m_wait)        return REL;
        if (branch_taken)  return BR;
        if (lu)            return LU;
        return DEF;
    endfunction

    logic [9:0] exp_o;
    always @(negedge clk) begin
        exp_o = model_out();
        chk("cycle_outs", {22'd0, outs}, {22'd0, exp_o});
        if (rst) begin
            m_stalls  = 0;
            m_flushes = 0;
        end
`ifdef HAZ_PERF_EN
        chk("stall_cycles", stall_cycles, 32'(m_stalls));
        chk("flush_events", flush_events, 32'(m_flushes));
`endif
        if (!rst && !m_fault) begin
            if (!exp_o[9])             m_stalls++;
            if (exp_o == BR)           m_flushes++;
        end
        if (rst) begin
            m_wait = 0; m_fault = 0; m_run = 0;
        end else if (!m_fault) begin
            if (waiting_now()) begin
                m_run++;
                if (m_run >= TO) begin m_fault = 1; m_wait = 0; end
                else m_wait = 1;
            end else begin
                m_run = 0; m_wait = 0;
            end
        end
    end

    task automatic go(input logic req, input logic rdy, input logic br, input logic lmr,
                      input int rd, input int rs, input int rt, input logic urt);
        @(posedge clk);
        #1;
        mem_req = req; mem_ready = rdy; branch_taken = br; ex_mem_read = lmr;
        ex_rd = AW'(rd); id_rs = AW'(rs); id_rt = AW'(rt); id_uses_rt = urt;
        #2;
    endtask

    int hold = 0;
`ifdef HAZ_PERF_EN
    logic [31:0] s0;
`endif

    initial begin
        #3 chk("reset_outs", {22'd0, outs}, {22'd0, RSTV});
        @(posedge clk); #1 rst = 1'b0;
        #2 chk("post_reset_default", {22'd0, outs}, {22'd0, DEF});

        go(0, 0, 0, 1, 8, 8, 3, 0); chk("load_use_rs", {22'd0, outs}, {22'd0, LU});
        go(0, 0, 0, 1, 0, 0, 0, 1); chk("load_rd_zero", {22'd0, outs}, {22'd0, DEF});
        go(0, 0, 0, 1, 5, 1, 5, 0); chk("load_rt_unused", {22'd0, outs}, {22'd0, DEF});
        go(0, 0, 0, 1, 5, 1, 5, 1); chk("load_use_rt", {22'd0, outs}, {22'd0, LU});
        go(0, 0, 1, 1, 8, 8, 0, 0); chk("branch_over_lu", {22'd0, outs}, {22'd0, BR});

        go(1, 0, 0, 0, 0, 0, 0, 0); chk("wait_c1", {22'd0, outs}, {22'd0, FRZ});
`ifdef HAZ_PERF_EN
        s0 = stall_cycles;
`endif
        go(1, 0, 0, 0, 0, 0, 0, 0); chk("wait_c2", {22'd0, outs}, {22'd0, FRZB});
        go(1, 0, 0, 0, 0, 0, 0, 0); chk("wait_c3", {22'd0, outs}, {22'd0, FRZB});
        go(1, 1, 0, 0, 0, 0, 0, 0); chk("wait_ready", {22'd0, outs}, {22'd0, REL});
`ifdef HAZ_PERF_EN
        chk("stall_delta3", stall_cycles - s0, 32'd3);
`endif
        go(0, 0, 0, 0, 0, 0, 0, 0); chk("after_ready", {22'd0, outs}, {22'd0, DEF});

        go(1, 0, 1, 0, 0, 0, 0, 0); chk("stall_with_br", {22'd0, outs}, {22'd0, FRZ});
        go(1, 1, 1, 0, 0, 0, 0, 0); chk("release_br_ign", {22'd0, outs}, {22'd0, REL});
        go(0, 0, 1, 0, 0, 0, 0, 0); chk("br_after_rel", {22'd0, outs}, {22'd0, BR});

        go(1, 0, 0, 0, 0, 0, 0, 0); chk("to_w1", {22'd0, outs}, {22'd0, FRZ});
        go(1, 0, 0, 0, 0, 0, 0, 0); chk("to_w2", {22'd0, outs}, {22'd0, FRZB});
        go(1, 0, 0, 0, 0, 0, 0, 0); chk("to_w3", {22'd0, outs}, {22'd0, FRZB});
        go(1, 0, 0, 0, 0, 0, 0, 0); chk("to_w4", {22'd0, outs}, {22'd0, FRZB});
        go(1, 0, 0, 0, 0, 0, 0, 0); chk("fault_set", {22'd0, outs}, {22'd0, FLT});
        go(0, 1, 1, 0, 0, 0, 0, 0); chk("fault_sticky", {22'd0, outs}, {22'd0, FLT});
        rst = 1'b1;
        #1 chk("fault_async_rst", {22'd0, outs}, {22'd0, RSTV});
        @(posedge clk); #1 rst = 1'b0; branch_taken = 1'b0; mem_ready = 1'b0;
        #2 chk("after_fault_rst", {22'd0, outs}, {22'd0, DEF});

        go(1, 0, 0, 0, 0, 0, 0, 0); chk("mw_w1", {22'd0, outs}, {22'd0, FRZ});
        go(1, 0, 0, 0, 0, 0, 0, 0); chk("mw_w2", {22'd0, outs}, {22'd0, FRZB});
        rst = 1'b1;
        #1 chk("midwait_async_rst", {22'd0, outs}, {22'd0, RSTV});
        @(posedge clk); #1 rst = 1'b0; mem_req = 1'b0;
        #2 chk("midwait_after", {22'd0, outs}, {22'd0, DEF});
        go(1, 0, 0, 0, 0, 0, 0, 0); chk("midwait_restart", {22'd0, outs}, {22'd0, FRZ});
        go(1, 1, 0, 0, 0, 0, 0, 0); chk("midwait_rel", {22'd0, outs}, {22'd0, REL});

        repeat (3000) begin
            @(posedge clk);
            #1;
            rst = ($urandom_range(0, 99) == 0);
            if (hold == 0 && $urandom_range(0, 79) == 0) hold = int'($urandom_range(2, 6));
            mem_req      = (hold > 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
            mem_ready    = (hold > 0) ? 1'b0 : ($urandom_range(0, 2) != 0);
            if (hold > 0) hold--;
            branch_taken = ($urandom_range(0, 5) == 0);
            ex_mem_read  = 1'($urandom_range(0, 1));
            id_uses_rt   = 1'($urandom_range(0, 1));
            ex_rd        = AW'($urandom_range(0, 3));
            id_rs        = AW'($urandom_range(0, 3));
            id_rt        = AW'($urandom_range(0, 3));
        end

        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
